// File: rtl/up_count_monitor_if.sv
// Count-stream bundle between an up-counter source and its sequence monitor.
interface up_count_monitor_if #(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 4
);
  logic [1:0]        count_in;
  logic              count_valid;
  logic              clear;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              err_pulse;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output count_in, count_valid, clear,
    input  locked, wrap_pulse, wrap_count, err_pulse, err_sticky, err_count
  );

  modport slave (
    input  count_in, count_valid, clear,
    output locked, wrap_pulse, wrap_count, err_pulse, err_sticky, err_count
  );
endinterface

// File: rtl/up_count_monitor.sv
// Checks a 2-bit up-count stream: locks after LOCK_CNT legal steps, counts 3->0 wraps
// while locked, and flags/counts/latches sequence errors seen while locked.
module up_count_monitor #(
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned LOCK_CNT = 2
) (
  input logic                clock,
  input logic                reset,
  up_count_monitor_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

  localparam logic [3:0] LockCntL = 4'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic [3:0]        run_q, run_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [1:0]        prev_inc;
  logic              legal;

  assign prev_inc = prev_q + 2'd1;
  assign legal    = (bus.count_in == prev_inc);

  // Next-state, pulse and statistics logic.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    wrap_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;

    if (bus.count_valid) begin
      prev_d = bus.count_in;
      case (state_q)
        StIdle: begin
          // First sample only seeds prev; it is never checked.
          state_d = StAcq;
          run_d   = 4'd0;
        end
        StAcq: begin
          if (legal) begin
            if (run_q + 4'd1 == LockCntL) begin
              state_d = StLocked;
              run_d   = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        StLocked: begin
          if (legal) begin
            if (prev_q == 2'd3) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + WRAP_W'(1);
            end
          end else begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            state_d = StAcq;
            run_d   = 4'd0;
          end
        end
        default: begin
          state_d = StIdle;
          run_d   = 4'd0;
        end
      endcase
    end

    // Clear beats a same-cycle increment or set; pulses are unaffected.
    if (bus.clear) begin
      wrap_count_d = '0;
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      prev_q       <= 2'd0;
      run_q        <= 4'd0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.locked     = (state_q == StLocked);
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_up_count_monitor.sv
// Bench for up_count_monitor: fixed vector table, directed corner sequences and a
// randomized stream checked against a behavioural model.
module tb_up_count_monitor;

  localparam int unsigned WRAP_W   = 8;
  localparam int unsigned ERR_W    = 4;
  localparam int unsigned LOCK_CNT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  up_count_monitor_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

  up_count_monitor #(.WRAP_W(WRAP_W), .ERR_W(ERR_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  bit m_started, m_locked, m_wp, m_ep, m_st;
  int m_prev, m_streak, m_wc, m_ec;

  typedef struct {
    bit valid; int cin; bit clr;
    bit locked; bit wp; bit ep; int wc; int ec; bit st;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_started = 0; m_locked = 0; m_wp = 0; m_ep = 0; m_st = 0;
    m_prev = 0; m_streak = 0; m_wc = 0; m_ec = 0;
  endfunction

  function automatic void model_step(input bit valid, input int cin, input bit clr);
    bit legal;
    m_wp = 0;
    m_ep = 0;
    if (valid) begin
      legal = (cin == (m_prev + 1) % 4);
      if (!m_started) begin
        m_started = 1;
        m_streak  = 0;
      end else if (m_locked) begin
        if (legal) begin
          if (m_prev == 3) begin
            m_wp = 1;
            m_wc = (m_wc + 1) % (1 << WRAP_W);
          end
        end else begin
          m_ep = 1;
          m_st = 1;
          if (m_ec < (1 << ERR_W) - 1) m_ec++;
          m_locked = 0;
          m_streak = 0;
        end
      end else if (legal) begin
        m_streak++;
        if (m_streak == LOCK_CNT) begin
          m_locked = 1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      m_prev = cin;
    end
    if (clr) begin
      m_wc = 0;
      m_ec = 0;
      m_st = 0;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".locked"}, int'(bus.locked), int'(m_locked));
    check({tag, ".wrap_pulse"}, int'(bus.wrap_pulse), int'(m_wp));
    check({tag, ".err_pulse"}, int'(bus.err_pulse), int'(m_ep));
    check({tag, ".wrap_count"}, int'(bus.wrap_count), m_wc);
    check({tag, ".err_count"}, int'(bus.err_count), m_ec);
    check({tag, ".err_sticky"}, int'(bus.err_sticky), int'(m_st));
  endtask

  // Apply one cycle on the falling edge, advance the model at the rising edge, sample #1 later.
  task automatic drive(input bit valid, input int cin, input bit clr, input string tag);
    @(negedge clock);
    bus.count_valid = valid;
    bus.count_in    = 2'(cin);
    bus.clear       = clr;
    @(posedge clock);
    model_step(valid, cin, clr);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset           = 1'b0;
    bus.count_valid = 1'b0;
    bus.count_in    = 2'd0;
    bus.clear       = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_model("reset");
    reset = 1'b1;
  endtask

  initial begin
    vec_t vecs[$];
    int p, wp_seen, ep_seen, last;
    bit v;

    bus.count_valid = 1'b0;
    bus.count_in    = 2'd0;
    bus.clear       = 1'b0;

    // Table: valid cin clr | locked wp ep wc ec sticky
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 3, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{1, 1, 0, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 3, 0, 0, 0, 1, 1, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 1, 0, 1, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 2, 0, 1, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 3, 0, 1, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 0, 1, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 1, 1});
    vecs.push_back('{1, 2, 1, 0, 0, 0, 0, 0, 0});

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clock);
      bus.count_valid = vecs[i].valid;
      bus.count_in    = 2'(vecs[i].cin);
      bus.clear       = vecs[i].clr;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d.locked", i), int'(bus.locked), int'(vecs[i].locked));
      check($sformatf("vec%0d.wrap_pulse", i), int'(bus.wrap_pulse), int'(vecs[i].wp));
      check($sformatf("vec%0d.err_pulse", i), int'(bus.err_pulse), int'(vecs[i].ep));
      check($sformatf("vec%0d.wrap_count", i), int'(bus.wrap_count), vecs[i].wc);
      check($sformatf("vec%0d.err_count", i), int'(bus.err_count), vecs[i].ec);
      check($sformatf("vec%0d.err_sticky", i), int'(bus.err_sticky), int'(vecs[i].st));
    end

    // Eight full locked cycles: exactly eight single-cycle wrap pulses, no errors.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, i, 0, "wrap_lock");
    wp_seen = 0;
    ep_seen = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1, i % 4, 0, "wrap8");
      wp_seen += int'(bus.wrap_pulse);
      ep_seen += int'(bus.err_pulse);
    end
    check("wrap8.pulses", wp_seen, 8);
    check("wrap8.errs", ep_seen, 0);
    check("wrap8.count", int'(bus.wrap_count), 8);

    // Valid gaps with garbage on invalid cycles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1, i / 2, 0, "gaps");
      else drive(0, int'($urandom_range(0, 3)), 0, "gaps");
    end
    check("gaps.locked", int'(bus.locked), 1);
    check("gaps.err_count", int'(bus.err_count), 0);

    // Twenty lock/error alternations saturate the error counter.
    do_reset();
    drive(1, 0, 0, "sat");
    p = 0;
    ep_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, (p + 1) % 4, 0, "sat");
      drive(1, (p + 2) % 4, 0, "sat");
      drive(1, (p + 2) % 4, 0, "sat");
      ep_seen += int'(bus.err_pulse);
      p = (p + 2) % 4;
    end
    check("sat.pulses", ep_seen, 20);
    check("sat.err_count", int'(bus.err_count), 15);
    drive(1, (p + 1) % 4, 0, "sat_clr");
    drive(1, (p + 2) % 4, 0, "sat_clr");
    drive(1, (p + 2) % 4, 1, "sat_clr");
    check("sat_clr.err_pulse", int'(bus.err_pulse), 1);
    check("sat_clr.err_count", int'(bus.err_count), 0);
    check("sat_clr.err_sticky", int'(bus.err_sticky), 0);

    // Asynchronous reset mid-stream while locked with five wraps counted.
    do_reset();
    for (int i = 0; i < 23; i++) drive(1, i % 4, 0, "arst_pre");
    check("arst.pre_wrap_count", int'(bus.wrap_count), 5);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst.locked", int'(bus.locked), 0);
    check("arst.wrap_count", int'(bus.wrap_count), 0);
    check("arst.wrap_pulse", int'(bus.wrap_pulse), 0);
    check("arst.err_pulse", int'(bus.err_pulse), 0);
    check("arst.err_count", int'(bus.err_count), 0);
    check("arst.err_sticky", int'(bus.err_sticky), 0);
    model_reset();
    bus.count_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(1, 3, 0, "relock");
    check("relock.s0", int'(bus.locked), 0);
    drive(1, 0, 0, "relock");
    check("relock.s1", int'(bus.locked), 0);
    drive(1, 1, 0, "relock");
    check("relock.s2", int'(bus.locked), 1);

    // Randomized stream against the model.
    do_reset();
    last = 0;
    for (int i = 0; i < 400; i++) begin
      int c;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (last + 1) % 4;
      if (v) last = c;
      drive(v, c, ($urandom_range(0, 31) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_count_monitor.md
Name: up_count_monitor

Overview:
Downstream consumer of the 2-bit free-running up-counter FSM output. Samples the count stream and checks that each qualified sample is the previous one plus 1 mod 4. Declares lock after a run of legal steps, counts 3->0 wraps as a higher-order extension, and flags, counts and latches sequence errors for status logic.

Parameters:
WRAP_W, 8, width of wrap (terminal-count) counter
ERR_W, 4, width of error counter
LOCK_CNT, 2, consecutive legal transitions required to enter LOCKED (legal range 1..15)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
count_in  input  2  count value from upstream up-counter
count_valid  input  1  1 = count_in is a sample this cycle; 0 = cycle ignored
clear  input  1  synchronous clear of statistics (wrap_count, err_count, err_sticky)
locked  output  1  1 while FSM is in LOCKED
wrap_pulse  output  1  one-cycle pulse per counted 3->0 wrap
wrap_count  output  WRAP_W  number of counted wraps, modulo 2^WRAP_W
err_pulse  output  1  one-cycle pulse per detected sequence error
err_sticky  output  1  latched error flag
err_count  output  ERR_W  number of errors, saturating at 2^ERR_W-1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prev=0, run=0, and all outputs 0 immediately. Reset during operation aborts everything with no partial update. Outputs after release are as at power-up.
- All outputs are registered and change only on the rising clock edge that captures the sample (1-cycle latency from sample to flag).
- count_valid=0: state, prev, run and counters hold. Pulses are 0 that cycle. count_in is don't-care.
- Legal step: count_in == (prev+1) mod 4. A repeated value or any jump is illegal. On every valid sample, prev <= count_in.
- FSM states:
  - IDLE: on valid -> ACQ, run=0. The first sample is never checked.
  - ACQ, valid and legal: run+1 == LOCK_CNT -> LOCKED and run=0; otherwise run++.
  - ACQ, valid and illegal: run=0, stay ACQ. No error is flagged in ACQ.
  - LOCKED, valid and legal: stay. If prev=3 and count_in=0: wrap_pulse=1 and wrap_count++ (wraps modulo 2^WRAP_W).
  - LOCKED, valid and illegal: err_pulse=1, err_sticky=1, err_count++ (saturating), -> ACQ with run=0. The illegal sample becomes prev.
- Wraps in IDLE/ACQ are not counted. This includes the 3->0 step that achieves lock.
- locked = (state==LOCKED), registered. It drops on the same edge that raises err_pulse.
- clear=1: on that edge wrap_count, err_count and err_sticky <= 0, and clear wins over a simultaneous increment or set. clear does not affect state, prev, run, locked, or the pulses, which still fire for a same-cycle event.
- err_pulse and wrap_pulse are mutually exclusive by construction.

Test Plan:
- Reset released, valid=1, count_in 0,1,2,3,0,... -> locked=1 after the edge capturing 2 (LOCK_CNT=2); first wrap_pulse on the edge capturing the next 0; wrap_count=1.
- Locked stream, 8 full cycles 0..3 -> wrap_count=8; exactly 8 single-cycle wrap_pulses; err_pulse never high.
- Locked at prev=1, feed 3 -> err_pulse one cycle, err_sticky=1, err_count=1, locked=0; then feed 0,1 -> locked=1 again; err_sticky stays 1.
- valid toggling 1,0,1,0 with garbage count_in on invalid cycles and legal 0,1,2,3 on valid cycles -> locks, no errors; state holds through gaps.
- ERR_W=4, LOCK_CNT=1, 20 lock/error alternations -> err_count saturates at 15; clear asserted in the same cycle as an error -> err_count=0 and err_sticky=0, err_pulse still 1.
- Mid-stream with wrap_count=5 and locked, drive reset=0 asynchronously between edges -> all outputs 0 before the next edge; after release, the FSM restarts in IDLE and needs LOCK_CNT legal steps to relock.
